// File: rtl/ysyx_22040759_icache.sv
// ysyx_22040759_icache: direct-mapped read-only instruction cache, one 64-bit beat per line.
// Addresses below CACHE_BASE bypass the arrays; fence_i invalidates every line.
module ysyx_22040759_icache #(
    parameter int                LINES      = 64,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] CACHE_BASE = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [63:0]       cpu_rdata,
    input  logic              fence_i,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [63:0]       mem_rdata
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 3 - IDX;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [63:0]      data [LINES];
    logic             fence_pend;
    logic             fill_cach;

    logic [IDX-1:0]   req_idx;
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] fill_tag;
    logic             cacheable;
    logic             hit;
    logic             fill_en;

    assign req_idx   = cpu_addr[3 +: IDX];
    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    // The latched request address also indexes the fill, so the CPU side is free to be ignored in MISS.
    assign fill_idx  = mem_addr[3 +: IDX];
    assign fill_tag  = mem_addr[ADDR_W-1 -: TAG_W];
    assign cacheable = cpu_addr >= CACHE_BASE;
    assign hit       = cacheable && valid[req_idx] && (tags[req_idx] == req_tag);
    assign fill_en   = (state == MISS) && mem_ready && fill_cach;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            fence_pend <= 1'b0;
            fill_cach  <= 1'b0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fence_i) begin
                        valid <= '0;
                    end
                    if (cpu_valid) begin
                        if (hit && !fence_i) begin
                            cpu_ready <= 1'b1;
                            cpu_rdata <= data[req_idx];
                            state     <= RESP;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= {cpu_addr[ADDR_W-1:3], 3'b000};
                            fill_cach <= cacheable;
                            state     <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (fence_i) begin
                        fence_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= mem_rdata;
                        state     <= RESP;
                        if (fill_cach) begin
                            valid[fill_idx] <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                    // Deferred fence also drops the line filled by the miss just finished.
                    if (fence_pend || fence_i) begin
                        valid      <= '0;
                        fence_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_icache.sv
// tb_ysyx_22040759_icache: scoreboard bench with a line-level cache model and a
// responsive bridge model; directed scenarios followed by randomized fetches.
module tb_ysyx_22040759_icache;
    localparam int          LINES = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic [63:0] cpu_rdata;
    logic        fence_i = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    logic        br_ready = 1'b0;
    logic [63:0] br_data = '0;
    logic        st_ready = 1'b0;
    logic [63:0] st_data = '0;

    assign mem_ready = br_ready | st_ready;
    assign mem_rdata = st_ready ? st_data : br_data;

    ysyx_22040759_icache dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_valid(cpu_valid),
        .cpu_addr (cpu_addr),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .fence_i  (fence_i),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [63:0] data;
        bit          hit;
        int          cyc;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    bit          mv[LINES];
    logic [31:0] mline[LINES];

    int          cycle = 0;
    int          mem_reqs = 0;
    int          errors = 0;
    int          checks = 0;
    int          issue_cycle = 0;
    int          fix_lat = -1;
    logic [31:0] exp_mem_addr = '0;
    bit          bridge_en = 1'b1;

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cycle++;
    end

    // Memory image: distinct per aligned address, with the known cold-miss word.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0010) return 64'h1122_3344_5566_7788;
        return {a ^ 32'h5A5A_C3C3, ~a};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Bridge: answers each request after a random or fixed latency.
    initial begin : bridge
        int lat;
        forever begin
            @(negedge clock);
            if (bridge_en && mem_valid) begin
                check("mem_addr", {32'h0, mem_addr}, {32'h0, exp_mem_addr});
                check("mem_req_latency", 64'(cycle - issue_cycle), 64'd1);
                mem_reqs++;
                lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
                for (int i = 0; i < lat; i++) begin
                    @(negedge clock);
                    check("mem_valid_hold", {63'h0, mem_valid}, 64'd1);
                    check("mem_addr_hold", {32'h0, mem_addr}, {32'h0, exp_mem_addr});
                end
                br_data  = mem_word(mem_addr);
                br_ready = 1'b1;
                @(posedge clock);
                #1;
                br_ready = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every cpu_ready pulse.
    initial begin : monitor
        exp_t e;
        bit   prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (cpu_ready) begin
                check("ready_pulse", {63'h0, prev_ready}, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got rdata %h want no response", cpu_rdata);
                end else begin
                    e = sb.pop_front();
                    check("rdata", cpu_rdata, e.data);
                    check("bridge_reqs", 64'(mem_reqs - e.reqs), e.hit ? 64'd0 : 64'd1);
                    if (e.hit) check("hit_latency", 64'(cycle - e.cyc), 64'd1);
                end
            end
            prev_ready = cpu_ready;
        end
    end

    // fmode: 0 plain, 1 fence_i with the request in IDLE, 2 fence_i during MISS.
    task automatic fetch(input logic [31:0] a, input int fmode);
        logic [31:0] al;
        int          idx;
        bit          cach;
        bit          hit;
        bit          fenced;
        bit          done;
        al   = {a[31:3], 3'b000};
        idx  = int'((al >> 3) % LINES);
        cach = (a >= BASE);
        if (fmode == 1) model_clear();
        hit  = cach && mv[idx] && (mline[idx] == al);
        if (fmode == 2 && hit) fmode = 0;
        sb.push_back('{data: mem_word(al), hit: hit, cyc: cycle, reqs: mem_reqs});
        exp_mem_addr = al;
        issue_cycle  = cycle;
        if (!hit && cach) begin
            mv[idx]    = 1'b1;
            mline[idx] = al;
        end
        if (fmode == 2) model_clear();
        cpu_valid = 1'b1;
        cpu_addr  = a;
        fence_i   = (fmode == 1);
        fenced    = 1'b0;
        done      = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clock);
            #1;
            fence_i = 1'b0;
            if (cpu_ready) begin
                done = 1'b1;
            end else if (fmode == 2 && !fenced && mem_valid) begin
                fence_i = 1'b1;
                fenced  = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no cpu_ready for %h want response within 100 cycles", a);
        end
        cpu_valid = 1'b0;
        fence_i   = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic fence_idle();
        fence_i = 1'b1;
        @(posedge clock);
        #1;
        fence_i = 1'b0;
        model_clear();
    endtask

    initial begin : stim
        logic [31:0] a;
        int          r;
        int          fm;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check("reset_cpu_ready", {63'h0, cpu_ready}, 64'd0);
        check("reset_cpu_rdata", cpu_rdata, 64'd0);
        check("reset_mem_valid", {63'h0, mem_valid}, 64'd0);
        check("reset_mem_addr", {32'h0, mem_addr}, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        fix_lat = 3;
        fetch(32'h8000_0010, 0);
        fix_lat = -1;
        fetch(32'h8000_0014, 0);
        fetch(32'h8000_0210, 0);
        fetch(32'h8000_0010, 0);
        fetch(32'h8000_0014, 0);
        fence_idle();
        fetch(32'h8000_0010, 0);
        fetch(32'h8000_0010, 2);
        fetch(32'h8000_0010, 0);
        fetch(32'h8000_0010, 1);
        fetch(32'h8000_0010, 0);
        fetch(32'h3000_0004, 0);
        fetch(32'h3000_0004, 0);

        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)
                a = 32'h3000_0000 + ($urandom_range(0, 15) << 2);
            else
                a = BASE + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 7) << 3)
                    + $urandom_range(0, 7);
            r  = int'($urandom_range(0, 19));
            fm = (r < 2) ? 1 : (r < 4) ? 2 : 0;
            if (r == 19) fence_idle();
            fetch(a, fm);
        end

        // Reset in the middle of a miss, then a stale bridge response.
        fetch(32'h8000_0010, 0);
        fetch(32'h8000_0010, 0);
        bridge_en = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h3000_0008;
        @(posedge clock);
        #1;
        check("miss_mem_valid", {63'h0, mem_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mem_valid", {63'h0, mem_valid}, 64'd0);
        cpu_valid = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        st_data  = 64'hDEAD_BEEF_0BAD_F00D;
        st_ready = 1'b1;
        @(posedge clock);
        #1;
        st_ready = 1'b0;
        @(negedge clock);
        check("stale_cpu_ready", {63'h0, cpu_ready}, 64'd0);
        check("stale_cpu_rdata", cpu_rdata, 64'd0);
        check("stale_mem_valid", {63'h0, mem_valid}, 64'd0);
        bridge_en = 1'b1;
        @(posedge clock);
        #1;
        fetch(32'h8000_0010, 0);
        fetch(32'h8000_0014, 0);

        repeat (3) @(posedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_icache.md
Name: ysyx_22040759_icache

Overview:
Direct-mapped, read-only instruction cache between the CPU fetch port and the AXI bridge's instruction read channel. Each line is one 64-bit beat, matching the bridge's single-beat 64-bit read. Hits return in one cycle. A miss issues one bridge request, fills the line, then responds. Addresses below CACHE_BASE bypass the cache and are never allocated.

Parameters:
LINES, 64, number of lines; power of 2, >= 2; IDX = log2(LINES)
ADDR_W, 32, address width
CACHE_BASE, 32'h8000_0000, lowest cacheable address

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_valid  in  1  fetch request; held with stable cpu_addr until cpu_ready
cpu_addr  in  ADDR_W  fetch byte address
cpu_ready  out  1  one-cycle pulse: cpu_rdata valid, request complete
cpu_rdata  out  64  aligned 64-bit word containing cpu_addr; CPU selects half by addr[2]
fence_i  in  1  one-cycle pulse: invalidate all lines
mem_valid  out  1  bridge request (drives bridge icache_addr_valid_i); held until mem_ready
mem_addr  out  ADDR_W  bridge address, always {cpu_addr[ADDR_W-1:3],3'b000}
mem_ready  in  1  bridge data-valid pulse (bridge icache_data_valid_o)
mem_rdata  in  64  bridge read data

Behaviour:
- Clocking: single clock domain. Reset is asynchronous and active-high. All state is in flops, including tag, data and valid arrays; no SRAM macro.
- Reset values:
  - State = IDLE; all valid bits cleared; fence_pend = 0.
  - cpu_ready = 0, cpu_rdata = 0, mem_valid = 0, mem_addr = 0.
- Address split: offset = addr[2:0]; index = addr[3+IDX-1:3]; tag = addr[ADDR_W-1:3+IDX].
- cacheable = (cpu_addr >= CACHE_BASE).
- State machine (IDLE, MISS, RESP):
  - IDLE, cpu_valid=1, cacheable, valid[index] and tag match (hit):
    - next cycle: cpu_ready=1, cpu_rdata=data[index]; state -> RESP.
    - Hit latency: 1 cycle.
  - IDLE, cpu_valid=1, miss or uncacheable:
    - state -> MISS; latch the aligned address.
    - Next cycle: mem_valid=1 and mem_addr=latched address.
  - MISS: hold mem_valid and mem_addr until mem_ready=1. On mem_ready:
    - mem_valid=0 next cycle; cpu_ready=1 and cpu_rdata=mem_rdata next cycle; state -> RESP.
    - If cacheable: data[index]=mem_rdata, tag[index]=tag, valid[index]=1. An evicted line is overwritten silently.
    - Uncacheable: no array update.
  - RESP: cpu_ready deasserts next cycle; state -> IDLE. A new request is accepted only in IDLE, so back-to-back hits take 2 cycles each.
- cpu_ready is a strict single-cycle pulse. cpu_rdata holds its last value when cpu_ready=0.
- fence_i:
  - In IDLE: all valid bits cleared at the next edge. A cpu_valid in that same cycle is treated as a miss.
  - In MISS/RESP: sets fence_pend. The in-flight fill completes and its data is returned to the CPU. The valid clear is applied on entry to IDLE, which invalidates the just-filled line too.
- mem_ready outside MISS (stale bridge response after reset): ignored; no array or output change.
- cpu_valid dropping mid-MISS is illegal. No recovery is required; the bench must not drive it.
- Reset mid-miss: mem_valid drops immediately (asynchronous); all lines become invalid.

Test Plan:
- Cold miss: reset, cpu_valid, cpu_addr=0x8000_0010.
  - Required: mem_valid high one cycle later with mem_addr=0x8000_0010.
  - Bridge returns 0x1122334455667788 after 3 cycles. cpu_ready pulses once, the cycle after mem_ready, with that data.
- Hit: refetch 0x8000_0014.
  - Required: cpu_ready exactly 1 cycle after request, cpu_rdata=0x1122334455667788, mem_valid never asserted.
- Conflict eviction (LINES=64): fetch 0x8000_0010 then 0x8000_0210; both must miss. Refetch 0x8000_0010: must miss again, with mem_addr=0x8000_0010.
- fence_i:
  - Pulse in IDLE after the hit scenario; next fetch of 0x8000_0010 misses.
  - Pulse during MISS: the fill data is still returned, and the same address misses afterwards.
- Bypass: fetch 0x3000_0004 twice. Required: two bridge requests with mem_addr=0x3000_0000; never a hit.
- Reset mid-miss: assert reset while mem_valid=1.
  - Required: mem_valid=0 the same cycle. A late mem_ready is ignored.
  - Prior hit address 0x8000_0010 misses after reset.
